song_sequencer: RTL and testbench

SONG_SEQUENCER -- requirements
Module: song_sequencer

---
 rtl/song_sequencer_if.sv | 29 ++
 rtl/song_sequencer.sv | 174 +++++++++++++++++
 tb/tb_song_sequencer.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/song_sequencer_if.sv
// Control, song-ROM and note-output bundle of the song sequencer.
// The slave modport is the sequencer side. The master modport is the controller/ROM side.
interface song_sequencer_if;
  logic        start_in;
  logic        pause_in;
  logic        stop_in;
  logic [1:0]  song_sel_in;
  logic [7:0]  rom_addr_out;
  logic [11:0] rom_data_in;
  logic [6:0]  note_out;
  logic        note_valid_out;
  logic        note_strobe_out;
  logic [5:0]  note_idx_out;
  logic        busy_out;
  logic        done_out;
  logic [2:0]  state_out;

  modport slave (
    input  start_in, pause_in, stop_in, song_sel_in, rom_data_in,
    output rom_addr_out, note_out, note_valid_out, note_strobe_out,
           note_idx_out, busy_out, done_out, state_out
  );

  modport master (
    output start_in, pause_in, stop_in, song_sel_in, rom_data_in,
    input  rom_addr_out, note_out, note_valid_out, note_strobe_out,
           note_idx_out, busy_out, done_out, state_out
  );
endinterface

// File: rtl/song_sequencer.sv
// Plays a song from a synchronous ROM, one {note, beats} entry after another.
// Each note lasts beats*TICKS_PER_BEAT cycles. Start, pause and stop come in as single-cycle pulses.
module song_sequencer #(
  parameter int unsigned TICKS_PER_BEAT = 25_000_000
) (
  input  logic            clk_in,
  input  logic            rst_in,
  song_sequencer_if.slave bus
);

  localparam int unsigned TICK_W = 25;
  localparam int unsigned IDX_W  = 6;
  localparam int unsigned BEAT_W = 5;
  localparam int unsigned NOTE_W = 7;
  localparam int unsigned SONG_W = 2;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_BEAT - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = '1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_LOAD   = 3'd2,
    ST_PLAY   = 3'd3,
    ST_PAUSED = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  state_t              state, state_nx;
  logic [SONG_W-1:0]   song_reg, song_nx;
  logic [IDX_W-1:0]    idx, idx_nx;
  logic [TICK_W-1:0]   tick, tick_nx;
  logic [BEAT_W-1:0]   beat, beat_nx;
  logic [NOTE_W-1:0]   note_q, note_nx;
  logic                valid_q, valid_nx;
  logic                strobe_q, strobe_nx;
  logic                done_q, done_nx;
  logic                busy_q, busy_nx;
  logic                adv;

  logic [NOTE_W-1:0]   rom_note;
  logic [BEAT_W-1:0]   rom_beats;

  assign rom_note  = bus.rom_data_in[11:5];
  assign rom_beats = bus.rom_data_in[4:0];

  // Next-state and datapath logic.
  // Stop wins over pause, and pause wins over the tick advance.
  always_comb begin
    state_nx  = state;
    song_nx   = song_reg;
    idx_nx    = idx;
    tick_nx   = tick;
    beat_nx   = beat;
    note_nx   = note_q;
    valid_nx  = valid_q;
    adv       = 1'b0;

    if (state != ST_IDLE && bus.stop_in) begin
      state_nx = ST_IDLE;
      valid_nx = 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (bus.start_in) begin
            song_nx  = bus.song_sel_in;
            idx_nx   = '0;
            state_nx = ST_FETCH;
          end
        end
        ST_FETCH: state_nx = ST_LOAD;
        ST_LOAD: begin
          if (rom_beats == '0) begin
            state_nx = ST_DONE;
            valid_nx = 1'b0;
          end else begin
            note_nx  = rom_note;
            beat_nx  = rom_beats;
            tick_nx  = '0;
            valid_nx = 1'b1;
            state_nx = ST_PLAY;
          end
        end
        ST_PLAY: begin
          if (bus.pause_in) begin
            state_nx = ST_PAUSED;
            valid_nx = 1'b0;
          end else begin
            adv = 1'b1;
          end
        end
        // The resume cycle counts as a tick. This makes up for the pause-press cycle, which did not advance.
        ST_PAUSED: begin
          if (bus.pause_in) begin
            state_nx = ST_PLAY;
            valid_nx = 1'b1;
            adv      = 1'b1;
          end
        end
        ST_DONE: begin
          state_nx = ST_IDLE;
          valid_nx = 1'b0;
        end
        default: state_nx = ST_IDLE;
      endcase
    end

    if (adv) begin
      if (tick == TICK_LAST) begin
        tick_nx = '0;
        beat_nx = beat - BEAT_W'(1);
        if (beat == BEAT_W'(1)) begin
          if (idx == IDX_LAST) begin
            state_nx = ST_DONE;
            valid_nx = 1'b0;
          end else begin
            idx_nx   = idx + IDX_W'(1);
            state_nx = ST_FETCH;
          end
        end
      end else begin
        tick_nx = tick + TICK_W'(1);
      end
    end
  end

  assign strobe_nx = (state == ST_LOAD) && (state_nx == ST_PLAY);
  assign done_nx   = (state_nx == ST_DONE);
  assign busy_nx   = (state_nx != ST_IDLE);

  // State register.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      song_reg <= '0;
      idx      <= '0;
      tick     <= '0;
      beat     <= '0;
      note_q   <= '0;
      valid_q  <= 1'b0;
      strobe_q <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      song_reg <= song_nx;
      idx      <= idx_nx;
      tick     <= tick_nx;
      beat     <= beat_nx;
      note_q   <= note_nx;
      valid_q  <= valid_nx;
      strobe_q <= strobe_nx;
      done_q   <= done_nx;
      busy_q   <= busy_nx;
    end
  end

  assign bus.rom_addr_out    = {song_reg, idx};
  assign bus.note_out        = note_q;
  assign bus.note_valid_out  = valid_q;
  assign bus.note_strobe_out = strobe_q;
  assign bus.note_idx_out    = idx;
  assign bus.busy_out        = busy_q;
  assign bus.done_out        = done_q;
  assign bus.state_out       = state;

endmodule

// File: tb/tb_song_sequencer.sv
// Scoreboard bench for song_sequencer with TICKS_PER_BEAT=4.
// Expected note strobes and done pulses are queued at stimulus time and popped when the DUT produces them.
module tb_song_sequencer;

  localparam int unsigned TPB = 4;

  logic clk_in;
  logic rst_in;

  song_sequencer_if sif();

  song_sequencer #(.TICKS_PER_BEAT(TPB)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (sif)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // Synchronous song ROM model.
  logic [11:0] rom [256];
  always @(posedge clk_in) sif.rom_data_in <= rom[sif.rom_addr_out];

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [6:0] note;
    logic [5:0] idx;
  } strobe_exp_t;

  strobe_exp_t strobe_q[$];
  int          done_q[$];
  strobe_exp_t se;
  int          de;

  int n_checks = 0;
  int n_fail   = 0;
  int s0;
  int st1 [21] = '{0, 1, 2, 3, 3, 3, 3, 3, 3, 3, 3, 1, 2, 3, 3, 3, 3, 1, 2, 5, 0};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  function automatic strobe_exp_t mk(input int c, input logic [6:0] n, input logic [5:0] i);
    strobe_exp_t e;
    e.cyc  = c;
    e.note = n;
    e.idx  = i;
    return e;
  endfunction

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk_in) begin
    if (!rst_in) begin
      if (sif.note_strobe_out) begin
        if (strobe_q.size() == 0) begin
          check("strobe_extra", 32'(sif.note_strobe_out), 32'd0);
        end else begin
          se = strobe_q.pop_front();
          check("strobe_cyc",  32'(cyc), 32'(se.cyc));
          check("strobe_note", 32'(sif.note_out), 32'(se.note));
          check("strobe_idx",  32'(sif.note_idx_out), 32'(se.idx));
        end
      end
      if (sif.done_out) begin
        if (done_q.size() == 0) begin
          check("done_extra", 32'(sif.done_out), 32'd0);
        end else begin
          de = done_q.pop_front();
          check("done_cyc", 32'(cyc), 32'(de));
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 12'h000;
    rom[64] = {7'h01, 5'd2};
    rom[65] = {7'h04, 5'd1};
    rom[66] = {7'h55, 5'd0};
    for (int i = 0; i < 64; i++) rom[128 + i] = {7'(i + 1), 5'd1};

    sif.start_in    = 1'b0;
    sif.pause_in    = 1'b0;
    sif.stop_in     = 1'b0;
    sif.song_sel_in = 2'd1;
    rst_in = 1'b0;
    #2 rst_in = 1'b1;
    #2;
    check("rst_state", 32'(sif.state_out), 32'd0);
    check("rst_valid", 32'(sif.note_valid_out), 32'd0);
    check("rst_busy",  32'(sif.busy_out), 32'd0);
    check("rst_note",  32'(sif.note_out), 32'd0);
    check("rst_addr",  32'(sif.rom_addr_out), 32'd0);
    repeat (3) step();
    rst_in = 1'b0;
    repeat (2) step();

    // Basic play, with an ignored mid-song start that selects song 2.
    s0 = cyc;
    strobe_q.push_back(mk(s0 + 3, 7'h01, 6'd0));
    strobe_q.push_back(mk(s0 + 13, 7'h04, 6'd1));
    done_q.push_back(s0 + 19);
    sif.start_in = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      step();
      check("basic_state", 32'(sif.state_out), 32'(st1[k]));
      check("basic_valid", 32'(sif.note_valid_out), 32'((k >= 3) && (k <= 18)));
      check("basic_song",  32'(sif.rom_addr_out[7:6]), 32'd1);
      check("basic_busy",  32'(sif.busy_out), 32'(k <= 19));
      sif.start_in = (k == 5);
      if (k == 5) sif.song_sel_in = 2'd2;
    end
    sif.song_sel_in = 2'd1;
    step();

    // Pause in the first note and resume 25 cycles later.
    s0 = cyc;
    strobe_q.push_back(mk(s0 + 3, 7'h01, 6'd0));
    strobe_q.push_back(mk(s0 + 38, 7'h04, 6'd1));
    done_q.push_back(s0 + 44);
    sif.start_in = 1'b1;
    for (int k = 1; k <= 46; k++) begin
      step();
      sif.start_in = 1'b0;
      check("pause_valid", 32'(sif.note_valid_out), 32'(((k >= 3) && (k <= 5)) || ((k >= 31) && (k <= 43))));
      if (k == 6)  check("pause_state", 32'(sif.state_out), 32'd4);
      if (k == 20) check("pause_note_hold", 32'(sif.note_out), 32'h01);
      if (k == 31) check("resume_state", 32'(sif.state_out), 32'd3);
      sif.pause_in = (k == 5) || (k == 30);
    end

    // Stop in the second note. The replay afterwards restarts from idx 0.
    s0 = cyc;
    strobe_q.push_back(mk(s0 + 3, 7'h01, 6'd0));
    strobe_q.push_back(mk(s0 + 13, 7'h04, 6'd1));
    sif.start_in = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      step();
      sif.start_in = 1'b0;
      if (k == 15) begin
        check("stop_state", 32'(sif.state_out), 32'd0);
        check("stop_valid", 32'(sif.note_valid_out), 32'd0);
        check("stop_busy",  32'(sif.busy_out), 32'd0);
      end
      sif.stop_in = (k == 14);
    end
    s0 = cyc;
    strobe_q.push_back(mk(s0 + 3, 7'h01, 6'd0));
    strobe_q.push_back(mk(s0 + 13, 7'h04, 6'd1));
    done_q.push_back(s0 + 19);
    sif.start_in = 1'b1;
    for (int k = 1; k <= 21; k++) begin
      step();
      sif.start_in = 1'b0;
    end
    check("replay_idle", 32'(sif.state_out), 32'd0);

    // Stop and pause in the same cycle.
    s0 = cyc;
    strobe_q.push_back(mk(s0 + 3, 7'h01, 6'd0));
    sif.start_in = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      sif.start_in = 1'b0;
      if (k == 7) begin
        check("stoppause_state", 32'(sif.state_out), 32'd0);
        check("stoppause_valid", 32'(sif.note_valid_out), 32'd0);
      end
      sif.stop_in  = (k == 6);
      sif.pause_in = (k == 6);
    end

    // Full 64-entry song with no terminator.
    sif.song_sel_in = 2'd2;
    s0 = cyc;
    for (int i = 0; i < 64; i++) strobe_q.push_back(mk(s0 + 3 + 6 * i, 7'(i + 1), 6'(i)));
    done_q.push_back(s0 + 385);
    sif.start_in = 1'b1;
    for (int k = 1; k <= 390; k++) begin
      step();
      sif.start_in = 1'b0;
    end
    check("full_idle",    32'(sif.state_out), 32'd0);
    check("full_idx",     32'(sif.note_idx_out), 32'd63);
    check("full_strobes", 32'(strobe_q.size()), 32'd0);

    // Asynchronous reset in the middle of a note.
    sif.song_sel_in = 2'd1;
    s0 = cyc;
    strobe_q.push_back(mk(s0 + 3, 7'h01, 6'd0));
    sif.start_in = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step();
      sif.start_in = 1'b0;
    end
    check("pre_rst_state", 32'(sif.state_out), 32'd3);
    #2 rst_in = 1'b1;
    #1;
    check("arst_state",  32'(sif.state_out), 32'd0);
    check("arst_valid",  32'(sif.note_valid_out), 32'd0);
    check("arst_note",   32'(sif.note_out), 32'd0);
    check("arst_busy",   32'(sif.busy_out), 32'd0);
    check("arst_strobe", 32'(sif.note_strobe_out), 32'd0);
    check("arst_done",   32'(sif.done_out), 32'd0);
    check("arst_idx",    32'(sif.note_idx_out), 32'd0);
    check("arst_addr",   32'(sif.rom_addr_out), 32'd0);
    sif.start_in = 1'b1;
    step();
    step();
    check("rst_start_ignored", 32'(sif.state_out), 32'd0);
    sif.start_in = 1'b0;
    #2 rst_in = 1'b0;
    step();
    step();
    check("post_rst_state", 32'(sif.state_out), 32'd0);
    check("post_rst_busy",  32'(sif.busy_out), 32'd0);

    repeat (3) step();
    check("sb_strobe_empty", 32'(strobe_q.size()), 32'd0);
    check("sb_done_empty",   32'(done_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
